elastic_config_loader: RTL and testbench

- Upstream feeder of the PE array's configuration interface.
- Accepts per-PE, per-context configuration records over an elastic valid/stop stream, then writes each record into the addressed PE's config memory through the array-wide config bus with a one-hot per-PE write enable.
- After the last record it pulses start_exec to all PEs and holds mapping_context_max_id stable until the array reports completion.

---
 rtl/elastic_config_loader_if.sv | 36 +++
 rtl/elastic_config_loader.sv | 183 ++++++++++++++++++
 tb/tb_elastic_config_loader.sv | 378 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/elastic_config_loader_if.sv
// Record stream between the configuration source and elastic_config_loader.
// The source (master) presents one configuration record per cycle under
// valid_input; the loader (slave) throttles it with stop_input.
interface elastic_config_loader_if #(
    parameter int PE_INDEX_BIT_LENGTH     = 4,
    parameter int CONTEXT_SIZE_BIT_LENGTH = 4,
    parameter int INPUT_NUM_BIT_LENGTH    = 3,
    parameter int NEIGHBOR_PE_NUM         = 4,
    parameter int OPERATION_BIT_LENGTH    = 4,
    parameter int DATA_WIDTH              = 32
);
    logic [PE_INDEX_BIT_LENGTH-1:0]     rec_pe_index;
    logic [CONTEXT_SIZE_BIT_LENGTH-1:0] rec_context_index;
    logic [INPUT_NUM_BIT_LENGTH-1:0]    rec_input_PE_index_1;
    logic [INPUT_NUM_BIT_LENGTH-1:0]    rec_input_PE_index_2;
    logic [NEIGHBOR_PE_NUM-1:0]         rec_output_PE_index;
    logic [OPERATION_BIT_LENGTH-1:0]    rec_op;
    logic [DATA_WIDTH-1:0]              rec_const_data;
    logic                               rec_last;
    logic                               valid_input;
    logic                               stop_input;

    modport master (
        output rec_pe_index, rec_context_index, rec_input_PE_index_1,
               rec_input_PE_index_2, rec_output_PE_index, rec_op,
               rec_const_data, rec_last, valid_input,
        input  stop_input
    );

    modport slave (
        input  rec_pe_index, rec_context_index, rec_input_PE_index_1,
               rec_input_PE_index_2, rec_output_PE_index, rec_op,
               rec_const_data, rec_last, valid_input,
        output stop_input
    );
endinterface

// File: rtl/elastic_config_loader.sv
// Feeds the PE array configuration bus: accepts records from an elastic
// valid/stop stream, writes each into the addressed PE's config memory with a
// one-hot write enable, then pulses start_exec and waits for exec_done.
// Every output is a flop; the next value of each is computed combinationally.
module elastic_config_loader #(
    parameter int PE_NUM                  = 16,
    parameter int PE_INDEX_BIT_LENGTH     = 4,
    parameter int CONTEXT_SIZE_BIT_LENGTH = 4,
    parameter int INPUT_NUM_BIT_LENGTH    = 3,
    parameter int NEIGHBOR_PE_NUM         = 4,
    parameter int OPERATION_BIT_LENGTH    = 4,
    parameter int DATA_WIDTH              = 32,
    parameter int RECORD_COUNT_BIT_LENGTH = 9
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               load_request,
    input  logic [CONTEXT_SIZE_BIT_LENGTH-1:0] load_context_max_id,
    elastic_config_loader_if.slave             rec,
    output logic [INPUT_NUM_BIT_LENGTH-1:0]    config_input_PE_index_1,
    output logic [INPUT_NUM_BIT_LENGTH-1:0]    config_input_PE_index_2,
    output logic [NEIGHBOR_PE_NUM-1:0]         config_output_PE_index,
    output logic [OPERATION_BIT_LENGTH-1:0]    config_op,
    output logic [DATA_WIDTH-1:0]              config_const_data,
    output logic [CONTEXT_SIZE_BIT_LENGTH-1:0] config_index,
    output logic [PE_NUM-1:0]                  write_config_data,
    output logic                               start_exec,
    output logic [CONTEXT_SIZE_BIT_LENGTH-1:0] mapping_context_max_id,
    input  logic                               exec_done,
    output logic                               busy,
    output logic [RECORD_COUNT_BIT_LENGTH-1:0] record_count,
    output logic                               error
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        START = 2'd2,
        RUN   = 2'd3
    } state_t;

    localparam logic [PE_INDEX_BIT_LENGTH:0] PE_NUM_EXT = (PE_INDEX_BIT_LENGTH+1)'(PE_NUM);
    localparam logic [PE_NUM-1:0]            PE_ONE     = {{(PE_NUM-1){1'b0}}, 1'b1};

    state_t                             state_q, state_d;
    logic                               stop_q, stop_d;
    logic                               start_q, start_d;
    logic                               busy_q, busy_d;
    logic                               error_q, error_d;
    logic [PE_NUM-1:0]                  wen_q, wen_d;
    logic [RECORD_COUNT_BIT_LENGTH-1:0] count_q, count_d;
    logic [CONTEXT_SIZE_BIT_LENGTH-1:0] max_id_q, max_id_d;
    logic [CONTEXT_SIZE_BIT_LENGTH-1:0] cfg_index_q, cfg_index_d;
    logic [INPUT_NUM_BIT_LENGTH-1:0]    cfg_in1_q, cfg_in1_d;
    logic [INPUT_NUM_BIT_LENGTH-1:0]    cfg_in2_q, cfg_in2_d;
    logic [NEIGHBOR_PE_NUM-1:0]         cfg_out_q, cfg_out_d;
    logic [OPERATION_BIT_LENGTH-1:0]    cfg_op_q, cfg_op_d;
    logic [DATA_WIDTH-1:0]              cfg_const_q, cfg_const_d;

    logic accept;
    logic drop;

    // A record is taken only while LOAD is advertising stop_input low.
    assign accept = (state_q == LOAD) && rec.valid_input && !stop_q;
    // Records aimed past the mapped contexts or past the array are discarded.
    assign drop   = (rec.rec_context_index > max_id_q) ||
                    ({1'b0, rec.rec_pe_index} >= PE_NUM_EXT);

    // Next-state and next-output computation for the load sequencer.
    always_comb begin
        state_d     = state_q;
        error_d     = error_q;
        count_d     = count_q;
        max_id_d    = max_id_q;
        cfg_index_d = cfg_index_q;
        cfg_in1_d   = cfg_in1_q;
        cfg_in2_d   = cfg_in2_q;
        cfg_out_d   = cfg_out_q;
        cfg_op_d    = cfg_op_q;
        cfg_const_d = cfg_const_q;
        wen_d       = '0;
        // start_exec is the registered decode of START, so it lands one cycle
        // after the final write enable (which is visible during START).
        start_d     = (state_q == START);

        unique case (state_q)
            IDLE: begin
                if (load_request) begin
                    max_id_d = load_context_max_id;
                    count_d  = '0;
                    error_d  = 1'b0;
                    state_d  = LOAD;
                end
            end
            LOAD: begin
                if (accept) begin
                    if (drop) begin
                        error_d = 1'b1;
                    end else begin
                        wen_d       = PE_ONE << rec.rec_pe_index;
                        cfg_index_d = rec.rec_context_index;
                        cfg_in1_d   = rec.rec_input_PE_index_1;
                        cfg_in2_d   = rec.rec_input_PE_index_2;
                        cfg_out_d   = rec.rec_output_PE_index;
                        cfg_op_d    = rec.rec_op;
                        cfg_const_d = rec.rec_const_data;
                        if (count_q != '1) begin
                            count_d = count_q + 1'b1;
                        end
                    end
                    // A dropped final record still closes the load.
                    if (rec.rec_last) begin
                        state_d = START;
                    end
                end
            end
            START: begin
                state_d = RUN;
            end
            RUN: begin
                if (exec_done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        stop_d = (state_d != LOAD);
        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset forces IDLE with the stream stopped.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            stop_q      <= 1'b1;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
            error_q     <= 1'b0;
            wen_q       <= '0;
            count_q     <= '0;
            max_id_q    <= '0;
            cfg_index_q <= '0;
            cfg_in1_q   <= '0;
            cfg_in2_q   <= '0;
            cfg_out_q   <= '0;
            cfg_op_q    <= '0;
            cfg_const_q <= '0;
        end else begin
            state_q     <= state_d;
            stop_q      <= stop_d;
            start_q     <= start_d;
            busy_q      <= busy_d;
            error_q     <= error_d;
            wen_q       <= wen_d;
            count_q     <= count_d;
            max_id_q    <= max_id_d;
            cfg_index_q <= cfg_index_d;
            cfg_in1_q   <= cfg_in1_d;
            cfg_in2_q   <= cfg_in2_d;
            cfg_out_q   <= cfg_out_d;
            cfg_op_q    <= cfg_op_d;
            cfg_const_q <= cfg_const_d;
        end
    end

    assign rec.stop_input              = stop_q;
    assign start_exec                  = start_q;
    assign busy                        = busy_q;
    assign error                       = error_q;
    assign write_config_data           = wen_q;
    assign record_count                = count_q;
    assign mapping_context_max_id      = max_id_q;
    assign config_index                = cfg_index_q;
    assign config_input_PE_index_1     = cfg_in1_q;
    assign config_input_PE_index_2     = cfg_in2_q;
    assign config_output_PE_index      = cfg_out_q;
    assign config_op                   = cfg_op_q;
    assign config_const_data           = cfg_const_q;

endmodule

// File: tb/tb_elastic_config_loader.sv
// Self-checking bench for elastic_config_loader: scenario tasks drive the
// record stream; each expected write is queued when its record is driven and
// popped when a write enable appears on the configuration bus.
module tb_elastic_config_loader;

    localparam int PE_NUM = 16;

    typedef struct packed {
        logic [15:0] wen;
        logic [3:0]  ctx;
        logic [2:0]  in1;
        logic [2:0]  in2;
        logic [3:0]  outm;
        logic [3:0]  op;
        logic [31:0] cdata;
    } wr_t;

    typedef struct {
        wr_t w;
        int  cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        load_request;
    logic [3:0]  load_context_max_id;
    logic        exec_done;
    logic [2:0]  config_input_PE_index_1;
    logic [2:0]  config_input_PE_index_2;
    logic [3:0]  config_output_PE_index;
    logic [3:0]  config_op;
    logic [31:0] config_const_data;
    logic [3:0]  config_index;
    logic [15:0] write_config_data;
    logic        start_exec;
    logic [3:0]  mapping_context_max_id;
    logic        busy;
    logic [8:0]  record_count;
    logic        error;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    exp_t exp_q[$];

    elastic_config_loader_if #(
        .PE_INDEX_BIT_LENGTH(4), .CONTEXT_SIZE_BIT_LENGTH(4), .INPUT_NUM_BIT_LENGTH(3),
        .NEIGHBOR_PE_NUM(4), .OPERATION_BIT_LENGTH(4), .DATA_WIDTH(32)
    ) rec_if ();

    elastic_config_loader #(
        .PE_NUM(16), .PE_INDEX_BIT_LENGTH(4), .CONTEXT_SIZE_BIT_LENGTH(4),
        .INPUT_NUM_BIT_LENGTH(3), .NEIGHBOR_PE_NUM(4), .OPERATION_BIT_LENGTH(4),
        .DATA_WIDTH(32), .RECORD_COUNT_BIT_LENGTH(9)
    ) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .load_request            (load_request),
        .load_context_max_id     (load_context_max_id),
        .rec                     (rec_if),
        .config_input_PE_index_1 (config_input_PE_index_1),
        .config_input_PE_index_2 (config_input_PE_index_2),
        .config_output_PE_index  (config_output_PE_index),
        .config_op               (config_op),
        .config_const_data       (config_const_data),
        .config_index            (config_index),
        .write_config_data       (write_config_data),
        .start_exec              (start_exec),
        .mapping_context_max_id  (mapping_context_max_id),
        .exec_done               (exec_done),
        .busy                    (busy),
        .record_count            (record_count),
        .error                   (error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Drive one record at the current negedge and leave valid low at the next.
    task automatic send(input logic [3:0] pe, input logic [3:0] ctx, input logic [2:0] a,
                        input logic [2:0] b, input logic [3:0] om, input logic [3:0] op,
                        input logic [31:0] cd, input logic last, input logic drop);
        exp_t        e;
        logic [15:0] one;
        one = 16'h0001;
        rec_if.rec_pe_index         = pe;
        rec_if.rec_context_index    = ctx;
        rec_if.rec_input_PE_index_1 = a;
        rec_if.rec_input_PE_index_2 = b;
        rec_if.rec_output_PE_index  = om;
        rec_if.rec_op               = op;
        rec_if.rec_const_data       = cd;
        rec_if.rec_last             = last;
        rec_if.valid_input          = 1'b1;
        if (!drop) begin
            e.w.wen   = one << pe;
            e.w.ctx   = ctx;
            e.w.in1   = a;
            e.w.in2   = b;
            e.w.outm  = om;
            e.w.op    = op;
            e.w.cdata = cd;
            e.cyc     = cyc + 1;
            exp_q.push_back(e);
        end
        @(negedge clk);
        rec_if.valid_input = 1'b0;
        rec_if.rec_last    = 1'b0;
    endtask

    task automatic load_req(input logic [3:0] max_id);
        @(negedge clk);
        load_request        = 1'b1;
        load_context_max_id = max_id;
        @(negedge clk);
        load_request        = 1'b0;
    endtask

    task automatic run_to_idle();
        @(negedge clk);
        exec_done = 1'b1;
        @(negedge clk);
        exec_done = 1'b0;
    endtask

    task automatic monitor_writes();
        exp_t e;
        wr_t  got;
        forever begin
            @(negedge clk);
            if (write_config_data !== 16'h0000) begin
                got = {write_config_data, config_index, config_input_PE_index_1,
                       config_input_PE_index_2, config_output_PE_index, config_op,
                       config_const_data};
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_write got=%h at cycle %0d required=no write", got, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e.w || cyc != e.cyc) begin
                        n_fail++;
                        $display("FAIL write got=%h@%0d required=%h@%0d", got, cyc, e.w, e.cyc);
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; load_request = 1'b0; exec_done = 1'b0; load_context_max_id = '0;
        rec_if.valid_input = 1'b0; rec_if.rec_last = 1'b0; rec_if.rec_pe_index = '0;
        rec_if.rec_context_index = '0; rec_if.rec_input_PE_index_1 = '0;
        rec_if.rec_input_PE_index_2 = '0; rec_if.rec_output_PE_index = '0;
        rec_if.rec_op = '0; rec_if.rec_const_data = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({start_exec, busy, error, write_config_data, record_count, mapping_context_max_id} !== '0) begin
            n_fail++;
            $display("FAIL rst_ctrl got=%b%b%b %h %h %h required=all zero", start_exec, busy, error,
                     write_config_data, record_count, mapping_context_max_id);
        end
        n_checks++;
        if ({config_index, config_input_PE_index_1, config_input_PE_index_2, config_output_PE_index,
             config_op, config_const_data} !== '0) begin
            n_fail++;
            $display("FAIL rst_bus got=%h %h required=0", config_op, config_const_data);
        end
        n_checks++;
        if (rec_if.stop_input !== 1'b1) begin
            n_fail++; $display("FAIL rst_stop got=%b required=1", rec_if.stop_input);
        end
        reset_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (rec_if.stop_input !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL idle_hold got stop=%b busy=%b required stop=1 busy=0", rec_if.stop_input, busy);
        end
    endtask

    task automatic test_basic();
        load_req(4'd1);
        n_checks++;
        if (rec_if.stop_input !== 1'b0 || busy !== 1'b1 || mapping_context_max_id !== 4'd1 || record_count !== 9'd0) begin
            n_fail++;
            $display("FAIL load_entry got stop=%b busy=%b max=%0d cnt=%0d required 0 1 1 0",
                     rec_if.stop_input, busy, mapping_context_max_id, record_count);
        end
        send(4'd0, 4'd0, 3'd1, 3'd2, 4'h1, 4'h3, 32'h0000_1000, 1'b0, 1'b0);
        send(4'd0, 4'd1, 3'd3, 3'd4, 4'h2, 4'h4, 32'h0000_1001, 1'b0, 1'b0);
        send(4'd1, 4'd0, 3'd5, 3'd6, 4'h4, 4'h6, 32'h0000_1100, 1'b0, 1'b0);
        send(4'd1, 4'd1, 3'd7, 3'd0, 4'h8, 4'h7, 32'h0000_1101, 1'b1, 1'b0);
        n_checks++;
        if (start_exec !== 1'b0 || rec_if.stop_input !== 1'b1 || record_count !== 9'd4) begin
            n_fail++;
            $display("FAIL basic_start_state got start=%b stop=%b cnt=%0d required 0 1 4",
                     start_exec, rec_if.stop_input, record_count);
        end
        @(negedge clk);
        n_checks++;
        if (start_exec !== 1'b1 || busy !== 1'b1) begin
            n_fail++; $display("FAIL basic_start_pulse got start=%b busy=%b required 1 1", start_exec, busy);
        end
        exec_done = 1'b1;
        @(negedge clk);
        exec_done = 1'b0;
        n_checks++;
        if (start_exec !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL basic_done got start=%b busy=%b required 0 0", start_exec, busy);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL basic_pending got=%0d required=0", exp_q.size());
        end
    endtask

    task automatic test_gapped();
        load_req(4'd3);
        for (int i = 0; i < 6; i++) begin
            send(4'(i + 2), 4'(i % 4), 3'(i), 3'(7 - i), 4'(1 << (i % 4)), 4'd5, 32'hDEAD_BEEF,
                 (i == 5), 1'b0);
            if (i != 5) @(negedge clk);
        end
        n_checks++;
        if (record_count !== 9'd6 || error !== 1'b0) begin
            n_fail++; $display("FAIL gapped_count got cnt=%0d err=%b required 6 0", record_count, error);
        end
        run_to_idle();
    endtask

    task automatic test_drop();
        load_req(4'd1);
        send(4'd2, 4'd3, 3'd1, 3'd1, 4'h1, 4'h1, 32'h1111_1111, 1'b0, 1'b1);
        n_checks++;
        if (error !== 1'b1 || record_count !== 9'd0) begin
            n_fail++; $display("FAIL drop_flag got err=%b cnt=%0d required 1 0", error, record_count);
        end
        send(4'd3, 4'd1, 3'd2, 3'd3, 4'h3, 4'h9, 32'h2222_2222, 1'b0, 1'b0);
        n_checks++;
        if (error !== 1'b1 || record_count !== 9'd1) begin
            n_fail++; $display("FAIL drop_next got err=%b cnt=%0d required 1 1", error, record_count);
        end
        send(4'd4, 4'd0, 3'd4, 3'd5, 4'h5, 4'hA, 32'h3333_3333, 1'b1, 1'b0);
        run_to_idle();
        n_checks++;
        if (error !== 1'b1 || record_count !== 9'd2 || busy !== 1'b0) begin
            n_fail++; $display("FAIL drop_sticky got err=%b cnt=%0d busy=%b required 1 2 0", error, record_count, busy);
        end
    endtask

    task automatic test_run_ignored();
        load_req(4'd0);
        send(4'd5, 4'd2, 3'd0, 3'd0, 4'h0, 4'h2, 32'h4444_4444, 1'b1, 1'b1);
        n_checks++;
        if (rec_if.stop_input !== 1'b1 || busy !== 1'b1 || record_count !== 9'd0 || error !== 1'b1) begin
            n_fail++;
            $display("FAIL drop_last got stop=%b busy=%b cnt=%0d err=%b required 1 1 0 1",
                     rec_if.stop_input, busy, record_count, error);
        end
        @(negedge clk);
        n_checks++;
        if (start_exec !== 1'b1) begin
            n_fail++; $display("FAIL drop_last_start got=%b required=1", start_exec);
        end
        load_request = 1'b1; load_context_max_id = 4'd7;
        rec_if.rec_pe_index = 4'd6; rec_if.rec_context_index = 4'd0; rec_if.valid_input = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (rec_if.stop_input !== 1'b1 || busy !== 1'b1 || mapping_context_max_id !== 4'd0) begin
                n_fail++;
                $display("FAIL run_ignore got stop=%b busy=%b max=%0d required 1 1 0",
                         rec_if.stop_input, busy, mapping_context_max_id);
            end
        end
        load_request = 1'b0; rec_if.valid_input = 1'b0; exec_done = 1'b1;
        @(negedge clk);
        exec_done = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || error !== 1'b1) begin
            n_fail++; $display("FAIL run_exit got busy=%b err=%b required 0 1", busy, error);
        end
        load_req(4'd2);
        n_checks++;
        if (error !== 1'b0 || record_count !== 9'd0 || mapping_context_max_id !== 4'd2 || rec_if.stop_input !== 1'b0) begin
            n_fail++;
            $display("FAIL reload got err=%b cnt=%0d max=%0d stop=%b required 0 0 2 0",
                     error, record_count, mapping_context_max_id, rec_if.stop_input);
        end
    endtask

    task automatic test_reset_mid_load();
        send(4'd1, 4'd0, 3'd6, 3'd5, 4'hC, 4'hB, 32'h5555_5555, 1'b0, 1'b0);
        @(negedge clk);
        reset_n = 1'b0;
        rec_if.rec_pe_index = 4'd7; rec_if.rec_context_index = 4'd1;
        rec_if.rec_last = 1'b1; rec_if.valid_input = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({start_exec, busy, error, write_config_data, record_count, mapping_context_max_id,
             config_op, config_const_data} !== '0 || rec_if.stop_input !== 1'b1) begin
            n_fail++;
            $display("FAIL midload_reset got start=%b busy=%b err=%b wen=%h cnt=%0d stop=%b required all 0, stop 1",
                     start_exec, busy, error, write_config_data, record_count, rec_if.stop_input);
        end
        reset_n = 1'b1; rec_if.valid_input = 1'b0; rec_if.rec_last = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (start_exec !== 1'b0 || busy !== 1'b0) begin
                n_fail++; $display("FAIL midload_quiet got start=%b busy=%b required 0 0", start_exec, busy);
            end
        end
    endtask

    task automatic test_pe15();
        load_req(4'd0);
        send(4'd15, 4'd0, 3'd7, 3'd7, 4'hF, 4'hF, 32'hFFFF_FFFF, 1'b1, 1'b0);
        n_checks++;
        if (start_exec !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL pe15_write_cycle got start=%b busy=%b required 0 1", start_exec, busy);
        end
        @(negedge clk);
        n_checks++;
        if (start_exec !== 1'b1 || rec_if.stop_input !== 1'b1) begin
            n_fail++; $display("FAIL pe15_start got start=%b stop=%b required 1 1", start_exec, rec_if.stop_input);
        end
        @(negedge clk);
        n_checks++;
        if (start_exec !== 1'b0 || busy !== 1'b1 || record_count !== 9'd1) begin
            n_fail++;
            $display("FAIL pe15_run got start=%b busy=%b cnt=%0d required 0 1 1", start_exec, busy, record_count);
        end
        exec_done = 1'b1;
        @(negedge clk);
        exec_done = 1'b0;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL pe15_idle got busy=%b required 0", busy);
        end
    endtask

    task automatic test_saturation();
        load_req(4'd15);
        for (int i = 0; i < 515; i++) begin
            send(4'(i % 16), 4'((i / 16) % 16), 3'(i), 3'(i >> 3), 4'(i), 4'(i >> 4), 32'(i * 7),
                 (i == 514), 1'b0);
        end
        n_checks++;
        if (record_count !== 9'd511) begin
            n_fail++; $display("FAIL count_saturate got=%0d required=511", record_count);
        end
        run_to_idle();
    endtask

    initial begin
        fork
            monitor_writes();
        join_none
        test_reset();
        test_basic();
        test_gapped();
        test_drop();
        test_run_ignored();
        test_reset_mid_load();
        test_pe15();
        test_saturation();
        repeat (2) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL missing_writes got=%0d pending required=0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
